pattern_sequencer: RTL

Frame-synchronous controller that selects which test pattern the suite video generator renders. It takes user buttons and the generator's VBlank and drives the pattern select and invert controls into the video datapath. Every change is deferred to the next frame boundary, so a pattern never switches mid-frame. Optional auto-cycling supports unattended burn-in and demo use.

---
 rtl/suite_pkg.sv | 37 +++
 rtl/btn_edge.sv | 29 ++
 rtl/pattern_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/suite_pkg.sv
// rtl/suite_pkg.sv - shared pattern indices, sequencer FSM states and direction encoding
package suite_pkg;

    localparam int unsigned PAT_GRID        = 0;
    localparam int unsigned PAT_COLOR_BARS  = 1;
    localparam int unsigned PAT_GRAY_RAMP   = 2;
    localparam int unsigned PAT_CHECKER     = 3;
    localparam int unsigned PAT_SOLID       = 4;
    localparam int unsigned PAT_CONVERGENCE = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_NEXT = 2'd1,
        DIR_PREV = 2'd2
    } pend_dir_t;

    function automatic pend_dir_t req_dir(input logic nxt, input logic prv);
        if (nxt && !prv) return DIR_NEXT;
        if (prv && !nxt) return DIR_PREV;
        return DIR_NONE;
    endfunction

    // Opposite directions cancel; a repeat of the same direction is absorbed.
    function automatic pend_dir_t merge_dir(input pend_dir_t pend, input pend_dir_t req);
        if (req == DIR_NONE)  return pend;
        if (pend == DIR_NONE) return req;
        if (pend == req)      return pend;
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - button 2-FF synchroniser with rising-edge press strobe and held level
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press,
    output logic o_held
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync2_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_d <= 1'b0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
        end
    end

    assign o_press = r_sync2 & ~r_sync2_d;
    assign o_held  = r_sync2;

endmodule

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - frame-synchronous test pattern select/invert sequencer (optional SUITE_AUTO_CYCLE_EN)
module pattern_sequencer
    import suite_pkg::*;
#(
    parameter int NUM_PATTERNS  = 6,
    parameter int SEL_W         = 4,
    parameter int HOLD_FRAMES   = 30,
    parameter int REPEAT_FRAMES = 8,
    parameter int AUTO_FRAMES   = 600
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vblank,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             btn_invert,
    output logic [SEL_W-1:0] pattern_sel,
    output logic             invert,
    output logic             switch_pulse
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam int REP_W  = $clog2(REPEAT_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_FRAMES - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_PATTERNS - 1);

    logic w_press_next, w_held_next;
    logic w_press_prev, w_held_prev;
    logic w_press_inv,  w_held_inv;

    btn_edge u_btn_next (.clk(clk), .reset(reset), .i_btn(btn_next),   .o_press(w_press_next), .o_held(w_held_next));
    btn_edge u_btn_prev (.clk(clk), .reset(reset), .i_btn(btn_prev),   .o_press(w_press_prev), .o_held(w_held_prev));
    btn_edge u_btn_inv  (.clk(clk), .reset(reset), .i_btn(btn_invert), .o_press(w_press_inv),  .o_held(w_held_inv));

    logic r_vblank;
    logic w_tick;

    always_ff @(posedge clk) begin
        if (reset) r_vblank <= 1'b0;
        else       r_vblank <= vblank;
    end

    assign w_tick = vblank & ~r_vblank;

    // Auto-repeat: index 0 tracks next, index 1 tracks prev.
    logic [1:0]        w_held_one;
    logic [1:0]        w_rep_req;
    logic [HOLD_W-1:0] r_hold_cnt [2];
    logic [REP_W-1:0]  r_rep_cnt  [2];

    assign w_held_one[0] = w_held_next & ~w_held_prev;
    assign w_held_one[1] = w_held_prev & ~w_held_next;

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            w_rep_req[d] = w_tick & w_held_one[d] &
                           ((r_hold_cnt[d] == HOLD_LAST) ||
                            ((r_hold_cnt[d] == HOLD_MAX) && (r_rep_cnt[d] == REP_LAST)));
        end
    end

    always_ff @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset || !w_held_one[d]) begin
                r_hold_cnt[d] <= '0;
                r_rep_cnt[d]  <= '0;
            end else if (w_tick) begin
                if (r_hold_cnt[d] != HOLD_MAX)
                    r_hold_cnt[d] <= r_hold_cnt[d] + HOLD_W'(1);
                else if (r_rep_cnt[d] == REP_LAST)
                    r_rep_cnt[d] <= '0;
                else
                    r_rep_cnt[d] <= r_rep_cnt[d] + REP_W'(1);
            end
        end
    end

    logic w_auto_req;

`ifdef SUITE_AUTO_CYCLE_EN
    localparam int IDLE_W = $clog2(AUTO_FRAMES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(AUTO_FRAMES - 1);

    logic              w_user_active;
    logic [IDLE_W-1:0] r_idle_cnt;

    assign w_user_active = w_press_next | w_press_prev | w_press_inv |
                           w_held_next  | w_held_prev  | w_held_inv;
    assign w_auto_req    = w_tick & ~w_user_active & (r_idle_cnt == IDLE_LAST);

    always_ff @(posedge clk) begin
        if (reset || w_user_active || w_auto_req) r_idle_cnt <= '0;
        else if (w_tick)                          r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end
`else
    assign w_auto_req = 1'b0;
`endif

    logic      w_req_any;
    pend_dir_t w_req_dir;

    assign w_req_any = w_press_next | w_press_prev | w_press_inv | (|w_rep_req) | w_auto_req;
    assign w_req_dir = req_dir(w_press_next | w_rep_req[0] | w_auto_req,
                               w_press_prev | w_rep_req[1]);

    seq_state_t r_state,      w_state_nxt;
    pend_dir_t  r_pend_dir,   w_pend_dir_nxt;
    logic       r_pend_inv,   w_pend_inv_nxt;
    pend_dir_t  r_hold_dir,   w_hold_dir_nxt;
    logic       r_hold_inv,   w_hold_inv_nxt;
    logic       r_hold_valid, w_hold_valid_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pend_dir   <= DIR_NONE;
            r_pend_inv   <= 1'b0;
            r_hold_dir   <= DIR_NONE;
            r_hold_inv   <= 1'b0;
            r_hold_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_dir   <= w_pend_dir_nxt;
            r_pend_inv   <= w_pend_inv_nxt;
            r_hold_dir   <= w_hold_dir_nxt;
            r_hold_inv   <= w_hold_inv_nxt;
            r_hold_valid <= w_hold_valid_nxt;
        end
    end

    // A request landing on the applying frame tick is parked and re-armed after APPLY.
    always_comb begin
        w_state_nxt      = r_state;
        w_pend_dir_nxt   = r_pend_dir;
        w_pend_inv_nxt   = r_pend_inv;
        w_hold_dir_nxt   = DIR_NONE;
        w_hold_inv_nxt   = 1'b0;
        w_hold_valid_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt    = ST_PENDING;
                    w_pend_dir_nxt = w_req_dir;
                    w_pend_inv_nxt = w_press_inv;
                end
            end
            ST_PENDING: begin
                if (w_tick) begin
                    w_state_nxt      = ST_APPLY;
                    w_hold_valid_nxt = w_req_any;
                    w_hold_dir_nxt   = w_req_dir;
                    w_hold_inv_nxt   = w_press_inv;
                end else if (w_req_any) begin
                    w_pend_dir_nxt = merge_dir(r_pend_dir, w_req_dir);
                    w_pend_inv_nxt = r_pend_inv ^ w_press_inv;
                end
            end
            ST_APPLY: begin
                if (r_hold_valid || w_req_any) begin
                    w_state_nxt    = ST_PENDING;
                    w_pend_dir_nxt = merge_dir(r_hold_dir, w_req_dir);
                    w_pend_inv_nxt = r_hold_inv ^ w_press_inv;
                end else begin
                    w_state_nxt    = ST_IDLE;
                    w_pend_dir_nxt = DIR_NONE;
                    w_pend_inv_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_pend_dir_nxt = DIR_NONE;
                w_pend_inv_nxt = 1'b0;
            end
        endcase
    end

    logic [SEL_W-1:0] r_sel, w_sel_new;
    logic             r_inv;
    logic             r_pulse;

    always_comb begin
        w_sel_new = r_sel;
        case (r_pend_dir)
            DIR_NEXT: w_sel_new = (r_sel == SEL_LAST) ? '0 : r_sel + SEL_W'(1);
            DIR_PREV: w_sel_new = (r_sel == '0) ? SEL_LAST : r_sel - SEL_W'(1);
            default:  w_sel_new = r_sel;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel   <= SEL_W'(PAT_GRID);
            r_inv   <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (r_state == ST_APPLY) begin
                r_sel   <= w_sel_new;
                r_inv   <= r_inv ^ r_pend_inv;
                r_pulse <= (w_sel_new != r_sel) | r_pend_inv;
            end
        end
    end

    assign pattern_sel  = r_sel;
    assign invert       = r_inv;
    assign switch_pulse = r_pulse;

endmodule
